risc_data_path: RTL and testbench

RISC_DATA_PATH -- requirements
Module: risc_data_path

---
 rtl/risc_data_path.sv | 157 +++++++++++++++
 tb/tb_risc_data_path.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/risc_data_path.sv
// Multi-cycle 16-bit RISC datapath: PC/IR, 16x16 register file, ALU and
// byte-banked instruction/data memories, sequenced by an external controller.

module risc_mem16 #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [7:0] mem_even [2**AW];
  logic [7:0] mem_odd  [2**AW];

  // No reset on the arrays: contents are preloaded from outside.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_even[addr] <= wdata[7:0];
      mem_odd[addr]  <= wdata[15:8];
    end
  end

  assign rdata = {mem_odd[addr], mem_even[addr]};
endmodule

module risc_data_path (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_wr,
  input  logic        eqb,
  input  logic        pc_src,
  input  logic        alu_srcA,
  input  logic        regB,
  input  logic        read3,
  input  logic        reg_wr,
  input  logic        reg_dst,
  input  logic        mem_to_reg,
  input  logic        output_cont,
  input  logic        memr,
  input  logic        memw,
  input  logic [1:0]  regA,
  input  logic [1:0]  alu_op,
  input  logic [2:0]  alu_srcB,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [15:0] C,
  output logic [15:0] mdr,
  output logic [15:0] alu_out
);
  logic [15:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic [15:0] mdr_q, mdr_d, alu_out_q, alu_out_d;
  logic [15:0] register_file [16];

  logic [3:0]  f1, f2, f3, ra1, ra2, wa;
  logic [15:0] rd1, rd2, rd3, wd, op_a, op_b, alu_res;
  logic [15:0] imem_rdata, dmem_rdata;
  logic        zero, pc_en;

  risc_mem16 #(.AW(15)) u_imem (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc_q[15:1]),
    .wdata (16'h0000),
    .rdata (imem_rdata)
  );

  risc_mem16 #(.AW(15)) u_dmem (
    .clk   (clk),
    .we    (memw & rst_n),
    .addr  (alu_out_q[15:1]),
    .wdata (b_q),
    .rdata (dmem_rdata)
  );

  always_comb begin
    f1 = ir_q[11:8];
    f2 = ir_q[7:4];
    f3 = ir_q[3:0];
    case (regA)
      2'b00:   ra1 = f2;
      2'b01:   ra1 = f1;
      2'b10:   ra1 = f3;
      default: ra1 = 4'h0;
    endcase
    ra2 = regB ? f1 : f3;
    rd1 = register_file[ra1];
    rd2 = register_file[ra2];
    rd3 = register_file[f1];

    op_a = alu_srcA ? a_q : pc_q;
    case (alu_srcB)
      3'b000:  op_b = 16'h0002;
      3'b001:  op_b = b_q;
      3'b010:  op_b = {{8{ir_q[7]}}, ir_q[7:0]};
      3'b011:  op_b = {12'h000, ir_q[3:0]};
      3'b100:  op_b = {{3{ir_q[11]}}, ir_q[11:0], 1'b0};
      3'b101:  op_b = c_q;
      default: op_b = 16'h0000;
    endcase
    case (alu_op)
      2'b00:   alu_res = op_a + op_b;
      2'b01:   alu_res = op_a - op_b;
      2'b10:   alu_res = op_a & op_b;
      default: alu_res = op_a | op_b;
    endcase
    zero = (alu_res == 16'h0000);

    pc_en     = pc_wr | (eqb & zero);
    pc_d      = pc_en ? (pc_src ? alu_out_q : alu_res) : pc_q;
    // Fetch reads imem at the PC value before this edge's update.
    ir_d      = (pc_wr & ~pc_src) ? imem_rdata : ir_q;
    a_d       = rd1;
    b_d       = rd2;
    c_d       = read3 ? rd3 : c_q;
    alu_out_d = output_cont ? {ir_q[7:0], 8'h00} : alu_res;
    mdr_d     = memr ? dmem_rdata : mdr_q;

    wa = reg_dst ? 4'hF : f1;
    wd = mem_to_reg ? mdr_q : alu_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= 16'h0000;
      ir_q      <= 16'h0000;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      c_q       <= 16'h0000;
      mdr_q     <= 16'h0000;
      alu_out_q <= 16'h0000;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      mdr_q     <= mdr_d;
      alu_out_q <= alu_out_d;
    end
  end

  // Register file keeps its contents through reset but takes no writes then.
  always_ff @(posedge clk) begin
    if (rst_n && reg_wr) register_file[wa] <= wd;
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign A       = a_q;
  assign B       = b_q;
  assign C       = c_q;
  assign mdr     = mdr_q;
  assign alu_out = alu_out_q;
endmodule

// File: tb/tb_risc_data_path.sv
// Directed bench for risc_data_path: a table of one-cycle control vectors
// walking fetch/decode/execute/branch, then memory, link and reset sequences.

module tb_risc_data_path;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] pc, ir, a_o, b_o, c_o, mdr, alu_out;

  typedef struct packed {
    logic       pc_wr, eqb, pc_src, alu_srcA;
    logic [1:0] regA;
    logic       regB, read3;
    logic [1:0] alu_op;
    logic [2:0] alu_srcB;
    logic       output_cont, reg_wr, reg_dst, mem_to_reg, memr, memw;
  } ctrl_t;

  typedef struct {
    ctrl_t             c;
    logic [6:0]        m;
    logic [6:0][15:0]  e;
  } vec_t;

  localparam logic [6:0] M_PC = 7'b1000000, M_IR = 7'b0100000, M_A = 7'b0010000,
                         M_B = 7'b0001000, M_C = 7'b0000100, M_MDR = 7'b0000010,
                         M_ALU = 7'b0000001;
  localparam int NV = 21;

  ctrl_t c = '0;
  int checks = 0;
  int errors = 0;
  vec_t vt [NV];
  string fn [7] = '{"pc", "ir", "A", "B", "C", "mdr", "alu_out"};

  always #5 clk = ~clk;

  risc_data_path dut (
    .clk(clk), .rst_n(rst_n),
    .pc_wr(c.pc_wr), .eqb(c.eqb), .pc_src(c.pc_src), .alu_srcA(c.alu_srcA),
    .regB(c.regB), .read3(c.read3), .reg_wr(c.reg_wr), .reg_dst(c.reg_dst),
    .mem_to_reg(c.mem_to_reg), .output_cont(c.output_cont), .memr(c.memr),
    .memw(c.memw), .regA(c.regA), .alu_op(c.alu_op), .alu_srcB(c.alu_srcB),
    .pc(pc), .ir(ir), .A(a_o), .B(b_o), .C(c_o), .mdr(mdr), .alu_out(alu_out)
  );

  function automatic vec_t mk(ctrl_t cc, logic [6:0] m, logic [15:0] p, i, a, b,
                              cv, md, al);
    vec_t v;
    v.c = cc;
    v.m = m;
    v.e = {p, i, a, b, cv, md, al};
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(ctrl_t cc);
    c = cc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [6:0][15:0] act;

    for (int i = 0; i < 16; i++) dut.register_file[i] = 16'h0000;
    dut.register_file[0] = 16'hFF52;
    dut.register_file[1] = 16'h0001;
    dut.register_file[2] = 16'h0002;
    dut.register_file[3] = 16'h0005;
    dut.register_file[4] = 16'h0003;
    dut.u_imem.mem_even[0] = 8'h12;  dut.u_imem.mem_odd[0] = 8'h83;
    dut.u_imem.mem_even[1] = 8'h34;  dut.u_imem.mem_odd[1] = 8'hC1;
    dut.u_dmem.mem_even[32681] = 8'hFF;
    dut.u_dmem.mem_odd[32681]  = 8'hFF;

    //            controls                                                    mask                            pc     ir     A      B      C      mdr    alu
    vt[0]  = mk('{pc_wr:1'b1, default:'0},                                    M_PC|M_IR|M_ALU,                16'h2, 16'h8312, 0, 0, 0, 0, 16'h0002);
    vt[1]  = mk('{read3:1'b1, default:'0},                                    M_PC|M_A|M_B|M_C|M_ALU,         16'h2, 0, 16'h1, 16'h2, 16'h5, 0, 16'h0004);
    vt[2]  = mk('{alu_srcA:1'b1, alu_srcB:3'b001, default:'0},                M_A|M_B|M_C|M_ALU,              0, 0, 16'h1, 16'h2, 16'h5, 0, 16'h0003);
    vt[3]  = mk('{alu_srcA:1'b1, alu_srcB:3'b001, reg_wr:1'b1, default:'0},   M_ALU,                          0, 0, 0, 0, 0, 0, 16'h0003);
    vt[4]  = mk('{pc_wr:1'b1, read3:1'b1, default:'0},                        M_PC|M_IR|M_A|M_B|M_C|M_ALU,    16'h4, 16'hC134, 16'h1, 16'h2, 16'h3, 0, 16'h0004);
    vt[5]  = mk('{default:'0},                                                M_PC|M_IR|M_A|M_B|M_C|M_ALU,    16'h4, 16'hC134, 16'h3, 16'h3, 16'h3, 0, 16'h0006);
    vt[6]  = mk('{alu_srcA:1'b1, alu_srcB:3'b001, alu_op:2'b01, default:'0},  M_PC|M_A|M_B|M_ALU,             16'h4, 0, 16'h3, 16'h3, 0, 0, 16'h0000);
    vt[7]  = mk('{alu_srcA:1'b1, alu_srcB:3'b001, alu_op:2'b01, reg_wr:1'b1, default:'0}, M_ALU,              0, 0, 0, 0, 0, 0, 16'h0000);
    vt[8]  = mk('{regB:1'b1, alu_srcB:3'b011, alu_op:2'b01, default:'0},      M_PC|M_A|M_B|M_ALU,             16'h4, 0, 16'h3, 16'h0, 0, 0, 16'h0000);
    vt[9]  = mk('{eqb:1'b1, regB:1'b1, alu_srcB:3'b011, alu_op:2'b01, default:'0}, M_PC|M_IR|M_B|M_ALU,       16'h0, 16'hC134, 0, 16'h0, 0, 0, 16'h0000);
    vt[10] = mk('{eqb:1'b1, regB:1'b1, alu_srcB:3'b011, alu_op:2'b01, default:'0}, M_PC|M_ALU,                16'h0, 0, 0, 0, 0, 0, 16'hFFFC);
    vt[11] = mk('{output_cont:1'b1, default:'0},                              M_PC|M_ALU,                     16'h0, 0, 0, 0, 0, 0, 16'h3400);
    vt[12] = mk('{alu_srcB:3'b010, default:'0},                               M_ALU,                          0, 0, 0, 0, 0, 0, 16'h0034);
    vt[13] = mk('{alu_srcB:3'b100, default:'0},                               M_ALU,                          0, 0, 0, 0, 0, 0, 16'h0268);
    vt[14] = mk('{alu_srcA:1'b1, alu_op:2'b10, alu_srcB:3'b000, default:'0},  M_A|M_ALU,                      0, 0, 16'h3, 0, 0, 0, 16'h0002);
    vt[15] = mk('{alu_srcA:1'b1, alu_op:2'b11, alu_srcB:3'b010, default:'0},  M_ALU,                          0, 0, 0, 0, 0, 0, 16'h0037);
    vt[16] = mk('{alu_srcA:1'b1, alu_op:2'b01, alu_srcB:3'b010, default:'0},  M_ALU,                          0, 0, 0, 0, 0, 0, 16'hFFCF);
    vt[17] = mk('{alu_srcA:1'b1, alu_srcB:3'b101, default:'0},                M_C|M_ALU,                      0, 0, 0, 0, 16'h3, 0, 16'h0006);
    vt[18] = mk('{alu_srcA:1'b1, alu_srcB:3'b111, default:'0},                M_ALU,                          0, 0, 0, 0, 0, 0, 16'h0003);
    vt[19] = mk('{pc_wr:1'b1, pc_src:1'b1, default:'0},                       M_PC|M_IR|M_ALU,                16'h3, 16'hC134, 0, 0, 0, 0, 16'h0002);
    vt[20] = mk('{pc_wr:1'b1, default:'0},                                    M_PC|M_IR|M_ALU,                16'h5, 16'hC134, 0, 0, 0, 0, 16'h0005);

    // Power-on reset: outputs clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    act = {pc, ir, a_o, b_o, c_o, mdr, alu_out};
    for (int k = 6; k >= 0; k--) chk($sformatf("por.%s", fn[6-k]), act[k], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vt[i].c);
      act = {pc, ir, a_o, b_o, c_o, mdr, alu_out};
      for (int k = 6; k >= 0; k--)
        if (vt[i].m[k]) chk($sformatf("v%0d.%s", i, fn[6-k]), act[k], vt[i].e[k]);
    end

    // Data memory: address FF52 -> word 32681, read, write-with-read, readback.
    dut.register_file[1] = 16'h1234;
    step('{regA:2'b11, regB:1'b1, default:'0});
    chk("mem.A", a_o, 16'hFF52);
    chk("mem.B", b_o, 16'h1234);
    step('{regA:2'b11, regB:1'b1, alu_srcA:1'b1, alu_srcB:3'b110, default:'0});
    chk("mem.addr", alu_out, 16'hFF52);
    step('{regA:2'b11, regB:1'b1, alu_srcA:1'b1, alu_srcB:3'b110, memr:1'b1, default:'0});
    chk("mem.rd", mdr, 16'hFFFF);
    step('{regA:2'b11, regB:1'b1, alu_srcA:1'b1, alu_srcB:3'b110, memr:1'b1, memw:1'b1, default:'0});
    chk("mem.rdwr_old", mdr, 16'hFFFF);
    step('{regA:2'b11, regB:1'b1, alu_srcA:1'b1, alu_srcB:3'b110, memr:1'b1, default:'0});
    chk("mem.readback", mdr, 16'h1234);
    step('{regA:2'b11, regB:1'b1, alu_srcA:1'b1, alu_srcB:3'b110, reg_dst:1'b1,
           mem_to_reg:1'b1, reg_wr:1'b1, default:'0});
    chk("link.r15", dut.register_file[15], 16'h1234);
    chk("link.mdr_hold", mdr, 16'h1234);

    // Mid-cycle reset with active controls: immediate clear, then frozen.
    c = '{pc_wr:1'b1, read3:1'b1, memr:1'b1, reg_wr:1'b1, default:'0};
    #3 rst_n = 1'b0;
    #1;
    act = {pc, ir, a_o, b_o, c_o, mdr, alu_out};
    for (int k = 6; k >= 0; k--) chk($sformatf("rst.%s", fn[6-k]), act[k], 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold.pc", pc, 16'h0000);
    chk("rst_hold.ir", ir, 16'h0000);
    chk("rst_hold.mdr", mdr, 16'h0000);
    chk("rst_keep.r15", dut.register_file[15], 16'h1234);
    chk("rst_keep.r0", dut.register_file[0], 16'hFF52);
    @(negedge clk);
    rst_n = 1'b1;
    step('{pc_wr:1'b1, default:'0});
    chk("resume.pc", pc, 16'h0002);
    chk("resume.ir", ir, 16'h8312);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
